// File: rtl/cache_ctrl.sv
// Direct-mapped cache controller: read-allocate, write-through,
// write-update on hit, no-write-allocate on miss.
module cache_ctrl #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 3,
   parameter int IDX_W  = 2
) (
   input  logic                      clock,
   input  logic                      i_rst,
   input  logic                      cpu_req,
   input  logic                      cpu_we,
   input  logic [TAG_W+IDX_W-1:0]    cpu_addr,
   input  logic [DATA_W-1:0]         cpu_wdata,
   output logic [DATA_W-1:0]         cpu_rdata,
   output logic                      cpu_ack,
   output logic                      busy,
   output logic [IDX_W-1:0]          c_address,
   output logic [1+TAG_W+DATA_W-1:0] c_data,
   output logic                      c_rden,
   output logic                      c_wren,
   input  logic [1+TAG_W+DATA_W-1:0] c_q,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [TAG_W+IDX_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata,
   input  logic                      mem_ack
);

   localparam int LINE_W = 1 + TAG_W + DATA_W;
   localparam int ADDR_W = TAG_W + IDX_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_MEM_RD,
      S_FILL,
      S_MEM_WR,
      S_RESP
   } state_t;

   state_t              state, state_nx;
   logic [ADDR_W-1:0]   req_addr;
   logic                req_we;
   logic [DATA_W-1:0]   req_wdata;
   logic [DATA_W-1:0]   fill_data;
   logic [DATA_W-1:0]   rdata_q;
   logic [TAG_W-1:0]    req_tag;
   logic                hit;

   assign req_tag   = req_addr[ADDR_W-1:IDX_W];
   assign hit       = c_q[LINE_W-1] & (c_q[LINE_W-2:DATA_W] == req_tag);
   assign cpu_rdata = rdata_q;
   assign c_address = req_addr[IDX_W-1:0];

   always_ff @(posedge clock or posedge i_rst) begin
      if (i_rst) begin
         state     <= S_IDLE;
         req_addr  <= '0;
         req_we    <= 1'b0;
         req_wdata <= '0;
         fill_data <= '0;
         rdata_q   <= '0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && cpu_req) begin
            req_addr  <= cpu_addr;
            req_we    <= cpu_we;
            req_wdata <= cpu_wdata;
         end
         if (state == S_LOOKUP && !req_we && hit)
            rdata_q <= c_q[DATA_W-1:0];
         if (state == S_MEM_RD && mem_ack)
            fill_data <= mem_rdata;
         if (state == S_FILL)
            rdata_q <= fill_data;
      end
   end

   always_comb begin
      state_nx  = state;
      cpu_ack   = 1'b0;
      busy      = (state != S_IDLE);
      c_rden    = 1'b0;
      c_wren    = 1'b0;
      c_data    = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         S_IDLE: begin
            if (cpu_req)
               state_nx = S_LOOKUP;
         end
         S_LOOKUP: begin
            c_rden = 1'b1;
            if (req_we) begin
               // write-through: the array is only updated when the line is already ours
               if (hit) begin
                  c_wren = 1'b1;
                  c_data = {1'b1, req_tag, req_wdata};
               end
               state_nx = S_MEM_WR;
            end else begin
               state_nx = hit ? S_RESP : S_MEM_RD;
            end
         end
         S_MEM_RD: begin
            mem_req  = 1'b1;
            mem_addr = req_addr;
            if (mem_ack)
               state_nx = S_FILL;
         end
         S_FILL: begin
            c_wren   = 1'b1;
            c_data   = {1'b1, req_tag, fill_data};
            state_nx = S_RESP;
         end
         S_MEM_WR: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = req_addr;
            mem_wdata = req_wdata;
            if (mem_ack)
               state_nx = S_RESP;
         end
         S_RESP: begin
            cpu_ack  = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized bench for cache_ctrl with a line-level cache model,
// a behavioural array and a main-memory responder.
module tb_cache_ctrl;

   logic        clock = 1'b0;
   logic        i_rst;
   logic        cpu_req;
   logic        cpu_we;
   logic [4:0]  cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_ack;
   logic        busy;
   logic [1:0]  c_address;
   logic [35:0] c_data;
   logic        c_rden;
   logic        c_wren;
   logic [35:0] c_q;
   logic        mem_req;
   logic        mem_we;
   logic [4:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   cache_ctrl dut (
      .clock     (clock),
      .i_rst     (i_rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ack   (cpu_ack),
      .busy      (busy),
      .c_address (c_address),
      .c_data    (c_data),
      .c_rden    (c_rden),
      .c_wren    (c_wren),
      .c_q       (c_q),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   always #5 clock = ~clock;

   // 4 x 36 array, reset together with the controller
   logic [35:0] arr [4];
   always @(posedge clock or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < 4; i++) arr[i] <= '0;
      end else if (c_wren) begin
         arr[c_address] <= c_data;
      end
   end
   assign c_q = arr[c_address];

   // reference model: cache lines, main memory, last read result
   bit          mv [4];
   logic [2:0]  mt [4];
   logic [31:0] md [4];
   logic [31:0] mem [32];
   logic [31:0] last_rd;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [35:0] obs,
                        input logic [35:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         mv[i] = 1'b0;
         mt[i] = '0;
         md[i] = '0;
      end
      last_rd = '0;
   endtask

   task automatic txn(input logic we, input logic [4:0] a,
                      input logic [31:0] wd, input int dly);
      logic [1:0]  idx;
      logic [2:0]  tg;
      logic [31:0] rd_val;
      logic [35:0] fill_line;
      bit          hit, saw_mem, saw_fill, got_ack;
      int          cyc, drv_at, waits;
      idx       = a[1:0];
      tg        = a[4:2];
      hit       = mv[idx] && (mt[idx] == tg);
      rd_val    = mem[a];
      saw_mem   = 1'b0;
      saw_fill  = 1'b0;
      got_ack   = 1'b0;
      fill_line = '0;
      drv_at    = -100;
      waits     = 0;
      @(negedge clock);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = a;
      cpu_wdata = wd;
      @(negedge clock);
      check("lookup_rden", 36'(c_rden), 36'd1);
      check("lookup_idx", 36'(c_address), 36'(idx));
      check("lookup_wren", 36'(c_wren), 36'(we && hit));
      if (we && hit)
         check("wr_hit_line", c_data, {1'b1, tg, wd});
      // request stays asserted with changing fields; only the latched copy counts
      cpu_addr  = 5'($urandom);
      cpu_wdata = $urandom;
      cpu_we    = 1'($urandom);
      cyc = 1;
      while (cyc < 60) begin
         @(negedge clock);
         cyc++;
         mem_ack = 1'b0;
         if (cpu_ack) begin
            got_ack = 1'b1;
            break;
         end
         if (c_wren) begin
            saw_fill  = 1'b1;
            fill_line = c_data;
            check("fill_idx", 36'(c_address), 36'(idx));
         end
         if (mem_req) begin
            if (!saw_mem) begin
               check("mem_we", 36'(mem_we), 36'(we));
               check("mem_addr", 36'(mem_addr), 36'(a));
               check("mem_wdata", 36'(mem_wdata), we ? 36'(wd) : 36'd0);
            end
            saw_mem = 1'b1;
            if (waits == dly) begin
               mem_ack   = 1'b1;
               mem_rdata = mem[mem_addr];
               drv_at    = cyc;
            end else begin
               mem_rdata = $urandom;
            end
            waits++;
         end
      end
      check("ack_seen", 36'(got_ack), 36'd1);
      if (!we && hit)
         check("hit_latency", 36'(cyc), 36'd2);
      else
         check("mem_latency", 36'(cyc - drv_at), we ? 36'd1 : 36'd2);
      check("mem_txn", 36'(saw_mem), 36'(we || !hit));
      check("fill_seen", 36'(saw_fill), 36'(!we && !hit));
      if (!we && !hit)
         check("fill_line", fill_line, {1'b1, tg, rd_val});
      if (!we) begin
         if (!hit) begin
            mv[idx] = 1'b1;
            mt[idx] = tg;
            md[idx] = rd_val;
         end
         last_rd = md[idx];
      end else begin
         if (hit) md[idx] = wd;
         mem[a] = wd;
      end
      check("rdata", 36'(cpu_rdata), 36'(last_rd));
      cpu_req = 1'b0;
      mem_ack = 1'b0;
      @(negedge clock);
      check("ack_pulse", 36'(cpu_ack), 36'd0);
      check("idle", 36'(busy), 36'd0);
      check("arr_line", arr[idx], {mv[idx], mt[idx], md[idx]});
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 36'(busy), 36'd0);
      check({tag, "_ack"}, 36'(cpu_ack), 36'd0);
      check({tag, "_rdata"}, 36'(cpu_rdata), 36'd0);
      check({tag, "_creq"}, {c_rden, c_wren, c_address}, 36'd0);
      check({tag, "_cdata"}, c_data, 36'd0);
      check({tag, "_mreq"}, {mem_req, mem_we, mem_addr}, 36'd0);
      check({tag, "_mwdata"}, 36'(mem_wdata), 36'd0);
   endtask

   initial begin
      i_rst     = 1'b1;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      mem_rdata = '0;
      mem_ack   = 1'b0;
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      mem[5'h0A] = 32'hDEADBEEF;
      mem[5'h1A] = 32'h0BADF00D;
      model_reset();
      #1;
      check_all_zero("rst");
      repeat (3) @(negedge clock);
      i_rst = 1'b0;

      txn(1'b0, 5'h0A, 32'h0, 3);
      check("first_fill", arr[2], 36'hA_DEADBEEF);
      txn(1'b0, 5'h0A, 32'h0, 0);
      txn(1'b0, 5'h1A, 32'h0, 2);
      check("conflict_fill", arr[2], 36'hE_0BADF00D);
      txn(1'b0, 5'h0A, 32'h0, 1);
      txn(1'b0, 5'h1A, 32'h0, 0);
      txn(1'b1, 5'h1A, 32'h12345678, 2);
      check("wr_hit_arr", arr[2], 36'hE_12345678);
      txn(1'b0, 5'h1A, 32'h0, 0);
      txn(1'b1, 5'h03, 32'h55, 1);
      txn(1'b0, 5'h03, 32'h0, 0);

      for (int n = 0; n < 150; n++)
         txn($urandom_range(0, 2) == 0, 5'($urandom),
             $urandom, int'($urandom_range(0, 3)));

      // reset while a read miss waits on memory
      txn(1'b0, 5'h05, 32'h0, 0);
      @(negedge clock);
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = (mv[1] && mt[1] == 3'd1) ? 5'h09 : 5'h05;
      @(negedge clock);
      @(negedge clock);
      check("pre_rst_mreq", 36'(mem_req), 36'd1);
      #2 i_rst = 1'b1;
      #1;
      check_all_zero("mid_rst");
      cpu_req = 1'b0;
      model_reset();
      repeat (3) begin
         @(negedge clock);
         check("rst_no_ack", 36'(cpu_ack), 36'd0);
      end
      i_rst = 1'b0;
      txn(1'b0, 5'h0A, 32'h0, 1);
      txn(1'b0, 5'h0A, 32'h0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
